// File: rtl/gci_std_fifo_wr_arbiter.sv
// Round-robin arbiter that shares the async FIFO write port among four requesters
// in bounded bursts, and sequences the FIFO remove pulse on a flush request.
module gci_std_fifo_wr_arbiter #(
    parameter int P_N          = 16,
    parameter int P_BURST      = 4,
    parameter int P_BURST_N    = 2,
    parameter int P_REMOVE_LEN = 4
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic [3:0]         iREQ_VALID,
    input  logic [4*P_N-1:0]   iREQ_DATA,
    output logic [3:0]         oREQ_ACK,
    input  logic               iFLUSH_REQ,
    output logic               oFLUSH_DONE,
    output logic               oFIFO_WR_EN,
    output logic [P_N-1:0]     oFIFO_WR_DATA,
    input  logic               iFIFO_FULL,
    output logic               oFIFO_REMOVE,
    output logic [1:0]         oOWNER,
    output logic               oOWNER_VALID
);

    localparam int P_RCNT_N = (P_REMOVE_LEN > 1) ? $clog2(P_REMOVE_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_REMOVE
    } state_t;

    state_t               state, state_n;
    logic [1:0]           owner, owner_n;
    logic [1:0]           last, last_n;
    logic [P_BURST_N-1:0] beat, beat_n;
    logic [P_RCNT_N-1:0]  rcnt, rcnt_n;
    logic                 done, done_n;

    logic                 rr_found;
    logic [1:0]           rr_pick;
    logic [1:0]           rr_cand;
    logic                 beat_ok;

    // Search starts just after the last owner; offset 4 wraps back onto last itself.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = last;
        rr_cand  = last;
        for (int unsigned i = 1; i <= 4; i++) begin
            rr_cand = last + 2'(i);
            if (!rr_found && iREQ_VALID[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    always_comb begin
        oFIFO_WR_DATA = iREQ_DATA[P_N-1:0];
        for (int unsigned k = 0; k < 4; k++) begin
            if (owner == 2'(k)) begin
                oFIFO_WR_DATA = iREQ_DATA[k*P_N +: P_N];
            end
        end
    end

    assign beat_ok = iREQ_VALID[owner] & ~iFIFO_FULL;

    always_comb begin
        state_n      = state;
        owner_n      = owner;
        last_n       = last;
        beat_n       = beat;
        rcnt_n       = rcnt;
        done_n       = 1'b0;
        oREQ_ACK     = '0;
        oFIFO_WR_EN  = 1'b0;
        oFIFO_REMOVE = 1'b0;
        oOWNER_VALID = 1'b0;
        oOWNER       = '0;

        case (state)
            ST_IDLE: begin
                if (iFLUSH_REQ) begin
                    state_n = ST_REMOVE;
                    rcnt_n  = '0;
                end else if (rr_found) begin
                    state_n = ST_GRANT;
                    owner_n = rr_pick;
                    beat_n  = '0;
                end
            end
            ST_GRANT: begin
                oOWNER_VALID    = 1'b1;
                oOWNER          = owner;
                oFIFO_WR_EN     = beat_ok;
                oREQ_ACK[owner] = beat_ok;
                if (beat_ok) begin
                    beat_n = beat + 1'b1;
                end
                if (iFLUSH_REQ) begin
                    state_n = ST_REMOVE;
                    last_n  = owner;
                    rcnt_n  = '0;
                end else if (!iREQ_VALID[owner] ||
                             (beat_ok && beat == P_BURST_N'(P_BURST - 1))) begin
                    state_n = ST_IDLE;
                    last_n  = owner;
                end
            end
            ST_REMOVE: begin
                oFIFO_REMOVE = 1'b1;
                if (rcnt == P_RCNT_N'(P_REMOVE_LEN - 1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end else begin
                    rcnt_n = rcnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            state <= ST_IDLE;
            owner <= '0;
            last  <= 2'd3;
            beat  <= '0;
            rcnt  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            beat  <= beat_n;
            rcnt  <= rcnt_n;
            done  <= done_n;
        end
    end

    assign oFLUSH_DONE = done;

endmodule

// File: tb/tb_gci_std_fifo_wr_arbiter.sv
// Scoreboard bench for gci_std_fifo_wr_arbiter: a transaction-level model predicts
// per-cycle control outputs and the FIFO write stream; a monitor compares them.
module tb_gci_std_fifo_wr_arbiter;

    localparam int N     = 16;
    localparam int BURST = 4;
    localparam int RLEN  = 4;

    logic           clk;
    logic           nrst;
    logic [3:0]     valid;
    logic [4*N-1:0] rdata;
    logic [3:0]     ack;
    logic           flush;
    logic           flush_done;
    logic           wr_en;
    logic [N-1:0]   wr_data;
    logic           full;
    logic           remove;
    logic [1:0]     owner;
    logic           owner_valid;

    gci_std_fifo_wr_arbiter #(
        .P_N(N),
        .P_BURST(BURST),
        .P_BURST_N(2),
        .P_REMOVE_LEN(RLEN)
    ) dut (
        .iCLOCK(clk),
        .inRESET(nrst),
        .iREQ_VALID(valid),
        .iREQ_DATA(rdata),
        .oREQ_ACK(ack),
        .iFLUSH_REQ(flush),
        .oFLUSH_DONE(flush_done),
        .oFIFO_WR_EN(wr_en),
        .oFIFO_WR_DATA(wr_data),
        .iFIFO_FULL(full),
        .oFIFO_REMOVE(remove),
        .oOWNER(owner),
        .oOWNER_VALID(owner_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ack;
        logic       wr_en;
        logic       remove;
        logic       done;
        logic [1:0] owner;
        logic       owner_valid;
    } ctl_t;

    ctl_t         exp_q[$];
    logic [N-1:0] data_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Model: -1 owner means no grant; m_rem > 0 means a flush is in progress.
    int m_owner;
    int m_beats;
    int m_last;
    int m_rem;
    bit m_done;
    int m_acks[4];
    int seq[4];

    function automatic logic [N-1:0] req_word(input int k);
        return {2'(k), 14'(seq[k])};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = 3;
        m_rem   = 0;
        m_done  = 1'b0;
    endtask

    task automatic cycle(input logic [3:0] v, input bit f, input bit fl, input bit rst);
        ctl_t e;
        bit   next_done;
        bit   ok;
        int   o;
        int   c;
        @(posedge clk);
        #1;
        valid = v;
        full  = f;
        flush = fl;
        nrst  = rst;
        for (int k = 0; k < 4; k++) rdata[k*N +: N] = req_word(k);

        e         = '0;
        e.done    = m_done;
        next_done = 1'b0;
        if (m_rem > 0) begin
            e.remove = 1'b1;
            m_rem--;
            if (m_rem == 0) next_done = 1'b1;
        end else if (m_owner >= 0) begin
            o             = m_owner;
            e.owner_valid = 1'b1;
            e.owner       = 2'(o);
            ok            = v[o] && !f;
            if (ok) begin
                e.ack[o] = 1'b1;
                e.wr_en  = 1'b1;
                data_q.push_back(req_word(o));
                seq[o]++;
                m_acks[o]++;
                m_beats++;
            end
            if (fl) begin
                m_last  = o;
                m_owner = -1;
                m_rem   = RLEN;
            end else if (!v[o] || m_beats == BURST) begin
                m_last  = o;
                m_owner = -1;
            end
        end else begin
            if (fl) begin
                m_rem = RLEN;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    c = (m_last + k) % 4;
                    if (m_owner < 0 && v[c]) begin
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end
        end
        m_done = next_done;
        exp_q.push_back(e);
        if (!rst) model_reset();
    endtask

    task automatic run_until_acks(input int k, input logic [3:0] v, input int target, input string tag);
        int n;
        n = 0;
        while (m_acks[k] < target && n < 20) begin
            cycle(v, 1'b0, 1'b0, 1'b1);
            n++;
        end
        vectors++;
        if (m_acks[k] < target) begin
            miscompares++;
            $display("FAIL %s: requester %0d reached %0d acks, required %0d within 20 cycles",
                     tag, k, m_acks[k], target);
        end
    endtask

    initial begin : monitor
        ctl_t         e;
        ctl_t         got;
        logic [N-1:0] d;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {ack, wr_en, remove, flush_done, owner, owner_valid};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL ctl @%0t: got ack=%b wr=%b rem=%b done=%b own=%0d ov=%b, required ack=%b wr=%b rem=%b done=%b own=%0d ov=%b",
                             $time, got.ack, got.wr_en, got.remove, got.done, got.owner, got.owner_valid,
                             e.ack, e.wr_en, e.remove, e.done, e.owner, e.owner_valid);
                end
                if (wr_en === 1'b1) begin
                    vectors++;
                    if (data_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL wr_data @%0t: got write %h, required no write", $time, wr_data);
                    end else begin
                        d = data_q.pop_front();
                        if (wr_data !== d) begin
                            miscompares++;
                            $display("FAIL wr_data @%0t: got %h, required %h", $time, wr_data, d);
                        end
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] rv;
        int         base;
        nrst  = 1'b0;
        valid = '0;
        full  = 1'b0;
        flush = 1'b0;
        rdata = '0;
        for (int k = 0; k < 4; k++) begin
            m_acks[k] = 0;
            seq[k]    = 0;
        end
        model_reset();
        repeat (2) @(posedge clk);

        // All four requesters, FIFO never full.
        repeat (24) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        repeat (6)  cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Requester 2 drops valid after two beats, then re-raises.
        base = m_acks[2];
        run_until_acks(2, 4'b0100, base + 2, "req2_two_beats");
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(4'b0100, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Requester 1 stalled by FIFO full after its first beat.
        base = m_acks[1];
        run_until_acks(1, 4'b0010, base + 1, "req1_first_beat");
        repeat (5) cycle(4'b0010, 1'b1, 1'b0, 1'b1);
        repeat (6) cycle(4'b0010, 1'b0, 1'b0, 1'b1);
        repeat (3) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Flush during beat 2 of requester 3, then requester 0 should win.
        base = m_acks[3];
        run_until_acks(3, 4'b1000, base + 1, "req3_first_beat");
        cycle(4'b1000, 1'b0, 1'b1, 1'b1);
        repeat (10) cycle(4'b1001, 1'b0, 1'b0, 1'b1);
        repeat (4)  cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Flush and request in the same IDLE cycle; second flush inside REMOVE.
        cycle(4'b0001, 1'b0, 1'b1, 1'b1);
        cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        cycle(4'b0001, 1'b0, 1'b1, 1'b1);
        repeat (8) cycle(4'b0001, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Reset during REMOVE cycle 2: no done pulse, requester 0 wins next.
        cycle(4'b0000, 1'b0, 1'b1, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
        repeat (4) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        rv = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (rv[k]) rv[k] = ($urandom_range(99) < 85);
                else       rv[k] = ($urandom_range(99) < 40);
            end
            cycle(rv, ($urandom_range(99) < 15), ($urandom_range(99) < 3),
                  !($urandom_range(199) == 0));
        end
        repeat (3) cycle(4'b0000, 1'b0, 1'b0, 1'b1);

        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0 || data_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d ctl / %0d data entries left, required 0 / 0",
                     exp_q.size(), data_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
